// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: operation encodings.
package pipe_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SSAT = 2'b10,
    OP_USAT = 2'b11
  } op_e;

endpackage

// File: rtl/pipe_adder_if.sv
// Valid/ready operand and result bus of the pipelined adder.
interface pipe_adder_if #(
  parameter int N = 10
);
  import pipe_adder_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         co;
  logic         ovf;

  // Producer/consumer side: drives operands, accepts results.
  modport master (
    output in_valid, a, b, ci, op, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, ci, op, out_ready,
    output in_ready, out_valid, s, co, ovf
  );

endinterface

// File: rtl/pipe_adder_seg_add.sv
// Combinational SEG-bit slice adder; the extra sum bit is the slice carry.
module seg_add #(
  parameter int SEG = 5
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, cin};
  assign sum   = total[SEG-1:0];
  assign cout  = total[SEG];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined N-bit adder: one SEG-bit slice per stage with registered carry,
// add/sub/signed-saturate/unsigned-saturate selected per transaction.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int N   = 10,
  parameter int SEG = 5
) (
  input  logic          clk,
  input  logic          r,
  pipe_adder_if.slave   bus
);

  localparam int STAGES = N / SEG;
  localparam int LAST   = STAGES - 1;

  if (N < 2 || (N % SEG) != 0) begin : g_bad_params
    $error("pipe_adder: N must be >= 2 and an exact multiple of SEG");
  end

  // Pipeline registers; element j is the output of stage j.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      b_q   [STAGES];
  logic [N-1:0]      res_q [STAGES];
  op_e               op_q  [STAGES];
  logic              ovf_q;

  // Stage inputs (entry conditioning for stage 0, previous register otherwise).
  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] st_cin;
  logic [N-1:0]      st_a   [STAGES];
  logic [N-1:0]      st_b   [STAGES];
  logic [N-1:0]      st_res [STAGES];
  op_e               st_op  [STAGES];

  logic [SEG-1:0]    slice_sum [STAGES];
  logic [STAGES-1:0] slice_co;
  logic [N-1:0]      res_next  [STAGES];

  logic              adv;
  logic              v;
  logic [N-1:0]      s_fin;
  logic              ovf_fin;

  // The whole pipeline moves unless a finished result is waiting on the consumer.
  assign adv          = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = valid_q[LAST];
  assign bus.s         = res_q[LAST];
  assign bus.co        = carry_q[LAST];
  assign bus.ovf       = ovf_q;

  // Route operands into each stage; subtraction is a + ~b + ~ci.
  always_comb begin
    st_valid[0] = bus.in_valid;
    st_a[0]     = bus.a;
    st_b[0]     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    st_cin[0]   = (bus.op == OP_SUB) ? ~bus.ci : bus.ci;
    st_res[0]   = '0;
    st_op[0]    = op_e'(bus.op);
    for (int j = 1; j < STAGES; j++) begin
      st_valid[j] = valid_q[j-1];
      st_a[j]     = a_q[j-1];
      st_b[j]     = b_q[j-1];
      st_cin[j]   = carry_q[j-1];
      st_res[j]   = res_q[j-1];
      st_op[j]    = op_q[j-1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    seg_add #(.SEG(SEG)) u_seg_add (
      .x    (st_a[gi][gi*SEG +: SEG]),
      .y    (st_b[gi][gi*SEG +: SEG]),
      .cin  (st_cin[gi]),
      .sum  (slice_sum[gi]),
      .cout (slice_co[gi])
    );
  end

  // Merge each freshly computed slice into the partial result it travels with.
  always_comb begin
    for (int j = 0; j < STAGES; j++) begin
      res_next[j]              = st_res[j];
      res_next[j][j*SEG +: SEG] = slice_sum[j];
    end
  end

  // Final-stage overflow detection and saturation.
  always_comb begin
    v = (st_a[LAST][N-1] == st_b[LAST][N-1]) &&
        (res_next[LAST][N-1] != st_a[LAST][N-1]);
    s_fin   = res_next[LAST];
    ovf_fin = v;
    case (st_op[LAST])
      OP_SSAT: begin
        if (v) s_fin = st_a[LAST][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
      OP_USAT: begin
        if (slice_co[LAST]) s_fin = '1;
        ovf_fin = slice_co[LAST];
      end
      default: ;
    endcase
  end

  // Shift every stage together on advance; reset drops all in-flight work.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int j = 0; j < STAGES; j++) begin
        a_q[j]   <= '0;
        b_q[j]   <= '0;
        res_q[j] <= '0;
        op_q[j]  <= OP_ADD;
      end
    end else if (adv) begin
      valid_q <= st_valid;
      carry_q <= slice_co;
      ovf_q   <= ovf_fin;
      for (int j = 0; j < STAGES; j++) begin
        a_q[j]   <= st_a[j];
        b_q[j]   <= st_b[j];
        op_q[j]  <= st_op[j];
        res_q[j] <= (j == LAST) ? s_fin : res_next[j];
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (N=10, SEG=5, latency 2).
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int N      = 10;
  localparam int SEG    = 5;
  localparam int STAGES = N / SEG;

  logic clk = 1'b0;
  logic r;
  int   vectors = 0;
  int   miscompares = 0;

  logic [N-1:0] va [16];
  logic [N-1:0] vb [16];
  logic [1:0]   vop [16];
  logic         vci [16];
  logic [N-1:0] es [16];
  logic         eco [16];
  logic         eovf [16];

  pipe_adder_if #(.N(N)) bus ();

  pipe_adder #(.N(N), .SEG(SEG)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [1:0] op, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic ci, input logic [N-1:0] s,
                      input logic co, input logic ovf);
    va[i] = a; vb[i] = b; vop[i] = op; vci[i] = ci;
    es[i] = s; eco[i] = co; eovf[i] = ovf;
  endtask

  // Stream n loaded vectors; out_ready is low for cycles [st0, st0+stlen).
  task automatic stream(input string name, input int n, input int st0, input int stlen);
    int  sent = 0;
    int  got = 0;
    bit  stalled;
    for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
      stalled       = (cyc >= st0) && (cyc < st0 + stlen);
      bus.out_ready = !stalled;
      bus.in_valid  = (sent < n);
      bus.a  = (sent < n) ? va[sent]  : '0;
      bus.b  = (sent < n) ? vb[sent]  : '0;
      bus.ci = (sent < n) ? vci[sent] : 1'b0;
      bus.op = (sent < n) ? vop[sent] : 2'b00;
      #2;
      if (stalled) begin
        check($sformatf("%s stall out_valid c%0d", name, cyc), 32'(bus.out_valid), 32'd1);
        check($sformatf("%s stall in_ready c%0d", name, cyc), 32'(bus.in_ready), 32'd0);
        check($sformatf("%s stall hold s c%0d", name, cyc), 32'(bus.s), 32'(es[got]));
      end else begin
        check($sformatf("%s in_ready c%0d", name, cyc), 32'(bus.in_ready), 32'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got == 0) check($sformatf("%s latency", name), 32'(cyc), 32'(STAGES));
        check($sformatf("%s s[%0d]", name, got), 32'(bus.s), 32'(es[got]));
        check($sformatf("%s co[%0d]", name, got), 32'(bus.co), 32'(eco[got]));
        check($sformatf("%s ovf[%0d]", name, got), 32'(bus.ovf), 32'(eovf[got]));
        $display("%s result %0d: s=%h co=%b ovf=%b", name, got, bus.s, bus.co, bus.ovf);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
    end
    check($sformatf("%s result count", name), 32'(got), 32'(n));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    check($sformatf("%s drained", name), 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    r = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.op = 2'b00;
    #12;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset s", 32'(bus.s), 32'd0);
    check("reset co", 32'(bus.co), 32'd0);
    check("reset ovf", 32'(bus.ovf), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    r = 1'b0;
    @(posedge clk); #1;

    // Test-plan singles.
    load(0, OP_ADD, 10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0); stream("add_carry", 1, 99, 0);
    load(0, OP_SUB, 10'h005, 10'h007, 1'b0, 10'h3FE, 1'b0, 1'b0); stream("sub_neg", 1, 99, 0);
    load(0, OP_SUB, 10'h200, 10'h001, 1'b0, 10'h1FF, 1'b1, 1'b1); stream("sub_ovf", 1, 99, 0);
    load(0, OP_SSAT, 10'h1FF, 10'h001, 1'b0, 10'h1FF, 1'b0, 1'b1); stream("ssat_pos", 1, 99, 0);
    load(0, OP_SSAT, 10'h200, 10'h3FF, 1'b0, 10'h200, 1'b1, 1'b1); stream("ssat_neg", 1, 99, 0);
    load(0, OP_SSAT, 10'h010, 10'h020, 1'b0, 10'h030, 1'b0, 1'b0); stream("ssat_none", 1, 99, 0);
    load(0, OP_USAT, 10'h3F0, 10'h020, 1'b0, 10'h3FF, 1'b1, 1'b1); stream("usat_sat", 1, 99, 0);
    load(0, OP_USAT, 10'h100, 10'h0FF, 1'b1, 10'h200, 1'b0, 1'b0); stream("usat_ci", 1, 99, 0);

    // Back-to-back adds with a three-cycle consumer stall.
    load(0, OP_ADD, 10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0);
    load(1, OP_ADD, 10'h001, 10'h002, 1'b0, 10'h003, 1'b0, 1'b0);
    load(2, OP_ADD, 10'h155, 10'h0AA, 1'b0, 10'h1FF, 1'b0, 1'b0);
    load(3, OP_ADD, 10'h2AA, 10'h155, 1'b0, 10'h3FF, 1'b0, 1'b0);
    load(4, OP_ADD, 10'h1F0, 10'h020, 1'b0, 10'h210, 1'b0, 1'b1);
    load(5, OP_ADD, 10'h010, 10'h3E0, 1'b0, 10'h3F0, 1'b0, 1'b0);
    stream("backpressure", 6, 3, 3);

    // Operation changes on every consecutive transaction.
    load(0, OP_SUB,  10'h005, 10'h007, 1'b0, 10'h3FE, 1'b0, 1'b0);
    load(1, OP_USAT, 10'h3F0, 10'h020, 1'b0, 10'h3FF, 1'b1, 1'b1);
    load(2, OP_SSAT, 10'h1FF, 10'h001, 1'b0, 10'h1FF, 1'b0, 1'b1);
    load(3, OP_ADD,  10'h0FF, 10'h100, 1'b1, 10'h200, 1'b0, 1'b1);
    load(4, OP_SUB,  10'h010, 10'h005, 1'b1, 10'h00A, 1'b1, 1'b0);
    stream("mixed_ops", 5, 99, 0);

    // Reset with two transactions in flight.
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.op = OP_ADD; bus.ci = 1'b0;
    bus.a = 10'h111; bus.b = 10'h111;
    @(posedge clk); #1;
    bus.a = 10'h0F0; bus.b = 10'h00F;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
    check("pre-reset s", 32'(bus.s), 32'h222);
    #2 r = 1'b1;
    #1;
    check("async reset out_valid", 32'(bus.out_valid), 32'd0);
    check("async reset s", 32'(bus.s), 32'd0);
    check("async reset in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #3;
    r = 1'b0;
    @(posedge clk); #1;
    check("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    check("post-reset out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1; bus.a = 10'h123; bus.b = 10'h001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) begin
        check("post-reset result s", 32'(bus.s), 32'h124);
        $display("post-reset result: s=%h", bus.s);
        seen++;
      end
      @(posedge clk); #1;
    end
    check("post-reset result count", 32'(seen), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's combinational N-bit adder.
- Splits the N-bit operation into SEG-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Supports add, subtract, signed-saturating add and unsigned-saturating add, selected per transaction.
- Sits in the input-buffer datapath between sample producers and accumulators, using valid/ready flow control on both sides.

Parameters:
- N, 10: operand and result width. Must satisfy N >= 2.
- SEG, 5: slice width. N mod SEG must be 0; elaboration fails otherwise.
- STAGES (localparam), N/SEG: pipeline depth, equal to latency in cycles.

Ports:
- clk, in, 1: rising-edge clock.
- r, in, 1: reset, asynchronous, active-high.
- in_valid, in, 1: input transaction valid.
- in_ready, out, 1: block can accept an input this cycle.
- a, in, N: operand A.
- b, in, N: operand B.
- ci, in, 1: carry-in for add modes; borrow-in for sub.
- op, in, 2: 00 add, 01 sub, 10 signed saturating add, 11 unsigned saturating add.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- s, out, N: result.
- co, out, 1: raw carry out of the MSB (for sub, 1 means no borrow).
- ovf, out, 1: signed overflow (modes 00/01/10) or unsigned overflow (mode 11).

Behaviour:
- Reset: r=1 asynchronously clears every stage valid bit, the carry registers and s/co/ovf to 0. in_ready reads 1 while r=1 and after release.
- Advance: adv = !out_valid | out_ready. The whole pipeline shifts when adv=1 and holds all registers when adv=0.
  - in_ready = adv (combinational).
  - An input is accepted when in_valid & in_ready.
  - Bubbles propagate as valid=0 and are not collapsed.
- Throughput: one transaction per cycle when unstalled.
- Latency: an input accepted at edge k presents its result with out_valid=1 after edge k+STAGES-1, i.e. STAGES register stages, last stage drives outputs.
- Operand conditioning at entry:
  - Sub: b' = ~b, cin = ~ci, so s = a - b - ci.
  - Other modes: b' = b, cin = ci.
- Stage j (0..STAGES-1):
  - Adds a[j*SEG +: SEG] + b'[j*SEG +: SEG] + carry from stage j-1 (cin for j=0).
  - Upper operand slices and op travel in delay registers alongside.
  - Completed lower result slices travel in delay registers alongside.
- Width rule: each slice sum is SEG+1 bits. The MSB is the inter-stage carry; the final-stage MSB is co. No truncation beyond N.
- Signed overflow: v = (a[N-1] == b'[N-1]) & (sum[N-1] != a[N-1]). Original a sign and conditioned b sign are carried to the last stage.
- Final stage, by op:
  - 00/01: s = sum, ovf = v.
  - 10: if v, s = a[N-1] ? {1,0...0} : {0,1...1}, else s = sum; ovf = v.
  - 11: if co, s = all ones, else s = sum; ovf = co.
  - co is always the raw carry.
- Stalled outputs: s/co/ovf/out_valid stay stable while out_valid & !out_ready.
- Boundaries:
  - SEG == N gives a single stage, latency 1.
  - A carry must propagate across every slice boundary, e.g. all-ones + 1.
  - Simultaneous accept and output consume in one cycle is required.
  - Reset mid-stream drops all in-flight transactions silently.
  - op changes between consecutive transactions must not corrupt in-flight ones.

Decomposition:
- Package pipe_adder_pkg: op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_SSAT=2'b10, OP_USAT=2'b11.
- Sub-module seg_add: combinational SEG-bit slice adder with inputs x, y, cin and outputs sum, cout. Instantiate one per stage via generate.

Test Plan (N=10, SEG=5, latency 2):
- op=00, a=0x3FF, b=0x001, ci=0 -> after 2 cycles s=0x000, co=1, ovf=0. Exercises the carry across the slice boundary.
- op=01, a=0x005, b=0x007, ci=0 -> s=0x3FE, co=0, ovf=0. Also a=0x200, b=0x001 -> s=0x1FF, ovf=1.
- op=10, a=0x1FF, b=0x001 -> s=0x1FF, ovf=1. Also a=0x200, b=0x3FF -> s=0x200, ovf=1. Also a=0x010, b=0x020 -> s=0x030, ovf=0.
- op=11, a=0x3F0, b=0x020 -> s=0x3FF, co=1, ovf=1. Also a=0x100, b=0x0FF, ci=1 -> s=0x200, co=0.
- Backpressure:
  - Stimulus: stream 6 back-to-back adds, hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 during the stall, s held stable, all 6 results delivered in order, none lost or duplicated.
- Reset mid-stream:
  - Stimulus: assert r asynchronously with 2 transactions in flight.
  - Required: out_valid=0 and s=0 immediately (same cycle, no edge). After release, in_ready=1 and the next result is the first post-reset input only.
